// File: rtl/if_prefetch_if.sv
// rtl/if_prefetch_if.sv - fetch request/response and instruction handshake bundle
interface if_prefetch_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    // Fetch unit side: issues requests, presents instructions.
    modport master (
        output mem_req_valid,
        output mem_req_addr,
        output inst_valid,
        output inst_pc,
        output inst_data,
        input  mem_req_ready,
        input  mem_rsp_valid,
        input  mem_rsp_data,
        input  inst_ready,
        input  redirect_valid,
        input  redirect_pc
    );

    // Environment side: instruction memory plus the core.
    modport slave (
        input  mem_req_valid,
        input  mem_req_addr,
        input  inst_valid,
        input  inst_pc,
        input  inst_data,
        output mem_req_ready,
        output mem_rsp_valid,
        output mem_rsp_data,
        output inst_ready,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - instruction prefetch front-end with redirect flush (optional IF_PREFETCH_BYPASS_EN)
module if_prefetch #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input logic           clk,
    input logic           rst,
    if_prefetch_if.master bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = CW + 2;

    typedef enum logic {
        S_RUN   = 1'b0,
        S_FLUSH = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic          w_flushing;

    logic [31:0]   r_fetch_pc;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_live;
    logic [CW-1:0] r_drop;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [31:0]   r_fifo_pc   [DEPTH];
    logic [31:0]   r_fifo_data [DEPTH];

    logic [SW-1:0] w_occupancy;
    logic          w_credit;
    logic          w_req_hs;
    logic          w_rsp_keep;
    logic          w_rsp_drop;
    logic          w_bypass;
    logic          w_byp_taken;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_rsp_pc;
    logic [CW-1:0] w_live_next;
    logic [CW-1:0] w_drop_next;
    logic [SW-1:0] w_drop_redir;
    logic          w_unused_lsb;

    // Redirect targets are word aligned; the low bits carry no information.
    assign w_unused_lsb = ^bus.redirect_pc[1:0];

    // Every slot in the FIFO, every live request and every doomed request
    // holds one credit, so a kept response always finds room.
    assign w_occupancy = SW'(r_count) + SW'(r_live) + SW'(r_drop);
    assign w_credit    = (w_occupancy < SW'(DEPTH));

    assign bus.mem_req_valid = !rst && w_credit;
    assign bus.mem_req_addr  = r_fetch_pc;
    assign w_req_hs          = bus.mem_req_valid && bus.mem_req_ready;

    // Live requests are consecutive words ending just below fetch_pc (any
    // redirect zeroes live), so the oldest live PC is fetch_pc - 4*live.
    assign w_rsp_pc = r_fetch_pc - 32'({r_live, 2'b00});

    // A response is kept only when nothing older is pending a drop and no
    // redirect is killing it this cycle.
    assign w_rsp_keep = bus.mem_rsp_valid && !w_flushing && !bus.redirect_valid;
    assign w_rsp_drop = bus.mem_rsp_valid && w_flushing;

`ifdef IF_PREFETCH_BYPASS_EN
    assign w_bypass    = !rst && (r_count == '0) && w_rsp_keep;
    assign w_byp_taken = w_bypass && bus.inst_ready;
`else
    assign w_bypass    = 1'b0;
    assign w_byp_taken = 1'b0;
`endif

    assign w_push = w_rsp_keep && !w_byp_taken;
    assign w_pop  = (r_count != '0) && bus.inst_ready;

    // Present the FIFO head, or the arriving word when it is forwarded.
    always_comb begin
        bus.inst_valid = !rst && ((r_count != '0) || w_bypass);
        bus.inst_pc    = 32'h0;
        bus.inst_data  = 32'h0;
        if (r_count != '0) begin
            bus.inst_pc   = r_fifo_pc[r_rd_ptr];
            bus.inst_data = r_fifo_data[r_rd_ptr];
        end else if (w_bypass) begin
            bus.inst_pc   = w_rsp_pc;
            bus.inst_data = bus.mem_rsp_data;
        end
    end

    // Outstanding-request bookkeeping; a redirect moves everything live plus
    // this cycle's accepted request into drop, minus the response it kills.
    always_comb begin
        w_drop_redir = SW'(r_drop) + SW'(r_live) + SW'(w_req_hs) - SW'(bus.mem_rsp_valid);
        w_live_next  = r_live + CW'(w_req_hs) - CW'(bus.mem_rsp_valid && !w_flushing);
        w_drop_next  = r_drop - CW'(w_rsp_drop);
        if (bus.redirect_valid) begin
            w_live_next = '0;
            w_drop_next = w_drop_redir[CW-1:0];
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next state: FLUSH exactly while stale responses remain to be dropped.
    always_comb begin
        w_state_next = r_state;
        if (bus.redirect_valid) begin
            w_state_next = (w_drop_next != '0) ? S_FLUSH : S_RUN;
        end else if ((r_state == S_FLUSH) && (w_drop_next == '0)) begin
            w_state_next = S_RUN;
        end
    end

    // FSM output: discard incoming words while flushing.
    always_comb begin
        w_flushing = (r_state == S_FLUSH);
    end

    // Fetch PC, counters and FIFO pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_pc <= RESET_PC;
            r_count    <= '0;
            r_live     <= '0;
            r_drop     <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            r_live <= w_live_next;
            r_drop <= w_drop_next;
            if (bus.redirect_valid) begin
                r_fetch_pc <= {bus.redirect_pc[31:2], 2'b00};
                r_count    <= '0;
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
            end else begin
                if (w_req_hs) begin
                    r_fetch_pc <= r_fetch_pc + 32'd4;
                end
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + 1'b1;
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - 1'b1;
                end
            end
        end
    end

    // FIFO storage; contents are meaningless until counted, so no reset.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_fifo_pc[r_wr_ptr]   <= w_rsp_pc;
            r_fifo_data[r_wr_ptr] <= bus.mem_rsp_data;
        end
    end

endmodule
